// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings and 7-segment constants shared by the traffic-light output stage
package traffic_pkg;
   typedef enum logic [1:0] {PH_TT_G = 2'b00, PH_TT_Y = 2'b01, PH_RC_G = 2'b10, PH_RC_Y = 2'b11} phase_t;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH = 8'hBF;
   // active-low {dp,g,f,e,d,c,b,a}, entry 9 first
   localparam logic [9:0][7:0] SEG_TABLE = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                            8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low segments, dash for non-decimal, optional blank
module seg7_decode
   import traffic_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [7:0] seg_n
);
   assign seg_n = blank ? SEG_BLANK : bcd > 4'd9 ? SEG_DASH : SEG_TABLE[bcd];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit countdown display plus blinking-yellow signal heads
module seg_scan_driver
   import traffic_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd250,
   parameter logic [7:0] BLINK_TICKS = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cnt_for_TT,
   input  logic [7:0] cnt_for_RC,
   input  logic [1:0] cur_state,
   output logic [7:0] seg_n,
   output logic [3:0] dig_n,
   output logic [2:0] light_TT,
   output logic [2:0] light_RC
);
   logic [15:0] presc;
   logic [1:0] idx, st_q;
   logic [7:0] snap_tt, snap_rc, blink_cnt, blink_cnt_d, seg_d;
   logic blink_ph, blink_ph_d, tick, st_chg, wrap, blank;
   logic [3:0] nib;
   logic [2:0] lt_d, lr_d;
   phase_t ph;
   assign tick = presc == SCAN_DIV - 16'd1;
   assign st_chg = cur_state != st_q;
   assign wrap = tick && blink_cnt == BLINK_TICKS - 8'd1;
   assign ph = phase_t'(cur_state);
   always_comb begin
      nib = idx == 2'd0 ? snap_tt[7:4] : idx == 2'd1 ? snap_tt[3:0] :
            idx == 2'd2 ? snap_rc[7:4] : snap_rc[3:0];
      blank = !idx[0] && nib == 4'd0;
      // a phase change restarts the blink lit and overrides any tick
      blink_cnt_d = st_chg ? 8'd0 : wrap ? 8'd0 : tick ? blink_cnt + 8'd1 : blink_cnt;
      blink_ph_d = st_chg ? 1'b1 : wrap ? !blink_ph : blink_ph;
      lt_d = {cur_state[1], ph == PH_TT_Y && blink_ph_d, ph == PH_TT_G};
      lr_d = {!cur_state[1], ph == PH_RC_Y && blink_ph_d, ph == PH_RC_G};
   end
   seg7_decode u_dec (.bcd(nib), .blank(blank), .seg_n(seg_d));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx <= '0;
         snap_tt <= '0;
         snap_rc <= '0;
         blink_cnt <= '0;
         blink_ph <= 1'b1;
         st_q <= 2'b00;
         seg_n <= SEG_BLANK;
         dig_n <= 4'hF;
         light_TT <= 3'b100;
         light_RC <= 3'b100;
      end else begin
         presc <= tick ? 16'd0 : presc + 16'd1;
         idx <= tick ? idx + 2'd1 : idx;
         if (tick && idx == 2'd3) begin
            snap_tt <= cnt_for_TT;
            snap_rc <= cnt_for_RC;
         end
         blink_cnt <= blink_cnt_d;
         blink_ph <= blink_ph_d;
         st_q <= cur_state;
         seg_n <= seg_d;
         // all digits off on the first clock of each slot to avoid ghosting
         dig_n <= tick ? 4'hF : ~(4'b0001 << idx);
         light_TT <= lt_d;
         light_RC <= lr_d;
      end
   end
endmodule
